ex_mc: RTL
==========

Name: ex_mc

Overview:
- Parametrised multi-cycle execute stage for the in-order pipeline. Sits between the id/ex register and the mem stage.
- Performs logic, shift and add/sub/set-less-than operations in one cycle, and signed/unsigned division iteratively.
- Outputs are registered and feed mem directly.
- While a division is in progress, the block raises a stall request to the pipeline controller.

Parameters:
- DATA_W, 32, operand/result width; must be a power of two, at least 8.
- ADDR_W, 5, register-file address width.
- SHAMT_W, log2(DATA_W), shift-amount bits taken from reg1_data_i.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_i  in  1  instruction present on inputs.
- flush_i  in  1  kill current and in-flight operation.
- alusel_i  in  3  result class: 0 none, 1 logic, 2 shift, 3 arith, 4 div.
- aluop_i  in  4  op within class (encodings below).
- reg1_data_i  in  DATA_W  operand A / shift amount.
- reg2_data_i  in  DATA_W  operand B / shifted value.
- waddr_i  in  ADDR_W  destination register.
- wreg_i  in  1  destination write enable.
- stall_req_o  out  1  hold upstream stages; inputs must stay stable while high.
- wreg_o  out  1  registered write enable to mem.
- waddr_o  out  ADDR_W  registered destination.
- wdata_o  out  DATA_W  registered result.
- whilo_o  out  1  HI/LO write strobe (division results).
- hi_o  out  DATA_W  remainder.
- lo_o  out  DATA_W  quotient.

Behaviour:
- Reset (rst=1 at posedge):
  - All outputs go to 0; FSM goes to IDLE; division datapath is cleared.
  - Reset overrides flush_i and any in-flight division.
- Opcode encodings:
  - Logic: 0 AND, 1 OR, 2 XOR, 3 NOR.
  - Shift: 0 SLL, 1 SRL, 2 SRA; amount is reg1_data_i[SHAMT_W-1:0].
  - Arith: 0 ADD, 1 SUB, 2 SLT (signed), 3 SLTU.
  - Div: 0 DIV (signed), 1 DIVU.
  - Undefined aluop within a class gives result 0.
- Arithmetic is modulo 2^DATA_W with no overflow trap. SLT/SLTU write 1 or 0, zero-extended.
- Single-cycle ops (alusel 0-3, valid_i=1, FSM IDLE):
  - Results are registered at the next posedge: wreg_o=wreg_i, waddr_o=waddr_i, wdata_o=result (0 for alusel 0).
  - whilo_o=0; stall_req_o stays 0.
- valid_i=0 in IDLE: wreg_o=0, whilo_o=0; waddr_o and wdata_o are don't-care but are driven to 0.
- stall_req_o is combinational from the FSM state and inputs.
- Division FSM states: IDLE, DIV_RUN, DIV_END.
- IDLE to DIV_RUN:
  - Condition: valid_i=1, alusel=4, divisor nonzero.
  - Latch |A| and |B| (absolute values for DIV, raw values for DIVU), the sign flags, and a counter set to 0.
  - stall_req_o=1 combinationally in this same cycle.
- Divide by zero:
  - IDLE goes to DIV_END directly.
  - Result is quotient all-ones and remainder = reg1_data_i.
  - Total stall is 1 cycle.
- DIV_RUN:
  - Restoring algorithm, one quotient bit per cycle, DATA_W cycles.
  - stall_req_o=1 throughout.
  - Counter reaching DATA_W-1 moves the FSM to DIV_END.
- DIV_END:
  - Apply signs: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - stall_req_o=0 combinationally.
  - At the posedge: whilo_o=1, hi_o=remainder, lo_o=quotient, wreg_o=0. Then go to IDLE.
  - Total: DATA_W+1 stall cycles, outputs visible DATA_W+2 edges after acceptance.
- Signed overflow (DIV of minimum value by -1): quotient = minimum value, remainder = 0. No exception.
- whilo_o is a one-cycle pulse. hi_o and lo_o hold their values until the next division completes.
- flush_i=1 at any posedge (rst=0):
  - FSM goes to IDLE, stall_req_o drops, wreg_o=0, whilo_o=0.
  - Division results are discarded; hi_o and lo_o keep their prior values.
- A new valid_i seen while in DIV_RUN or DIV_END is ignored; the upstream is stalled and re-presents the instruction.

Test Plan:
- Logic and shift:
  - OR 0x0000F0F0 | 0x00FF0000 -> wdata_o=0x00FFF0F0, wreg_o=1 one edge later.
  - SRA of 0x80000000 by 4 -> 0xF8000000.
  - SLL by amount 0x25 (uses 5 bits) -> shift by 5.
- Arithmetic:
  - SUB 0 - 1 -> 0xFFFFFFFF.
  - SLT 0xFFFFFFFF vs 1 -> 1.
  - SLTU same operands -> 0.
- DIV -7 / 2 (DATA_W=32):
  - stall_req_o high for exactly 33 cycles.
  - Then whilo_o pulses with lo_o=0xFFFFFFFD (-3) and hi_o=0xFFFFFFFF (-1).
  - DIVU 100 / 7 -> lo=14, hi=2.
- Divide by zero, DIVU 5 / 0 -> 1 stall cycle, lo_o=0xFFFFFFFF, hi_o=5.
- flush_i asserted on the 10th DIV_RUN cycle:
  - stall_req_o=0 next cycle, no whilo_o pulse, hi_o/lo_o unchanged.
  - Back-to-back ADD then executes normally.
- rst asserted mid-division -> all outputs 0 next edge, stall_req_o=0. Rerun with DATA_W=16, DIV 0x8000 / 0xFFFF -> lo=0x8000, hi=0.

Source files
------------

// File: rtl/ex_mc.sv
// Execute stage: single-cycle logic/shift/arith ops, iterative restoring divider.
// Division stalls the pipeline until its HI/LO result is ready.
module ex_mc #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [2:0]        alusel_i,
    input  logic [3:0]        aluop_i,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic              wreg_i,
    output logic              stall_req_o,
    output logic              wreg_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam logic [2:0] SelLogic = 3'd1;
    localparam logic [2:0] SelShift = 3'd2;
    localparam logic [2:0] SelArith = 3'd3;
    localparam logic [2:0] SelDiv   = 3'd4;

    typedef enum logic [1:0] {Idle, DivRun, DivEnd} state_e;

    state_e              state_q, state_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q, neg_rem_d;
    logic                wreg_q, wreg_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                whilo_q, whilo_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic [SHAMT_W-1:0]  shamt;
    logic [DATA_W-1:0]   result;
    logic                is_div;
    logic                div_signed;
    logic [DATA_W-1:0]   abs_a, abs_b;
    logic [DATA_W:0]     trial, diff;
    logic [DATA_W-1:0]   quot_fix, rem_fix;

    assign shamt      = reg1_data_i[SHAMT_W-1:0];
    assign is_div     = (alusel_i == SelDiv) && (aluop_i[3:1] == 3'd0);
    assign div_signed = (aluop_i[0] == 1'b0);
    assign abs_a      = (div_signed && reg1_data_i[DATA_W-1]) ? -reg1_data_i : reg1_data_i;
    assign abs_b      = (div_signed && reg2_data_i[DATA_W-1]) ? -reg2_data_i : reg2_data_i;

    // diff MSB set means the trial remainder is below the divisor (no subtract).
    assign trial    = {rem_q, dvd_q[DATA_W-1]};
    assign diff     = trial - {1'b0, dvs_q};
    assign quot_fix = neg_quot_q ? -dvd_q : dvd_q;
    assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        result = '0;
        case (alusel_i)
            SelLogic: begin
                case (aluop_i)
                    4'd0:    result = reg1_data_i & reg2_data_i;
                    4'd1:    result = reg1_data_i | reg2_data_i;
                    4'd2:    result = reg1_data_i ^ reg2_data_i;
                    4'd3:    result = ~(reg1_data_i | reg2_data_i);
                    default: result = '0;
                endcase
            end
            SelShift: begin
                case (aluop_i)
                    4'd0:    result = reg2_data_i << shamt;
                    4'd1:    result = reg2_data_i >> shamt;
                    4'd2:    result = $signed(reg2_data_i) >>> shamt;
                    default: result = '0;
                endcase
            end
            SelArith: begin
                case (aluop_i)
                    4'd0:    result = reg1_data_i + reg2_data_i;
                    4'd1:    result = reg1_data_i - reg2_data_i;
                    4'd2:    result = {{(DATA_W-1){1'b0}},
                                       $signed(reg1_data_i) < $signed(reg2_data_i)};
                    4'd3:    result = {{(DATA_W-1){1'b0}}, reg1_data_i < reg2_data_i};
                    default: result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        wreg_d     = 1'b0;
        waddr_d    = '0;
        wdata_d    = '0;
        whilo_d    = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        if (flush_i) begin
            state_d = Idle;
        end else begin
            case (state_q)
                Idle: begin
                    if (valid_i && is_div) begin
                        neg_quot_d = div_signed & (reg1_data_i[DATA_W-1] ^ reg2_data_i[DATA_W-1]);
                        neg_rem_d  = div_signed & reg1_data_i[DATA_W-1];
                        cnt_d      = '0;
                        rem_d      = '0;
                        dvd_d      = abs_a;
                        dvs_d      = abs_b;
                        state_d    = DivRun;
                        if (reg2_data_i == '0) begin
                            // Divide by zero: skip iteration, no sign fix-up.
                            neg_quot_d = 1'b0;
                            neg_rem_d  = 1'b0;
                            dvd_d      = '1;
                            rem_d      = reg1_data_i;
                            state_d    = DivEnd;
                        end
                    end else if (valid_i && alusel_i != SelDiv) begin
                        wreg_d  = wreg_i;
                        waddr_d = waddr_i;
                        wdata_d = result;
                    end
                end
                DivRun: begin
                    rem_d = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
                    dvd_d = {dvd_q[DATA_W-2:0], ~diff[DATA_W]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == SHAMT_W'(DATA_W - 1)) begin
                        state_d = DivEnd;
                    end
                end
                DivEnd: begin
                    whilo_d = 1'b1;
                    hi_d    = rem_fix;
                    lo_d    = quot_fix;
                    state_d = Idle;
                end
                default: state_d = Idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= Idle;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            wreg_q     <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            whilo_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            wreg_q     <= wreg_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            whilo_q    <= whilo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign stall_req_o = (state_q == DivRun) || ((state_q == Idle) && valid_i && is_div);
    assign wreg_o      = wreg_q;
    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;
    assign whilo_o     = whilo_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;

endmodule
